// File: rtl/ppu_raster_timing.sv
// Raster timing generator for the PPU: dot/line counters, vblank status flag, NMI,
// odd-frame dot skip and frame counter. The pre-render line is held as y_pos = 9'h1FF.
module ppu_raster_timing #(
  parameter int H_TOTAL  = 341,
  parameter int V_LINES  = 262,
  parameter int VIS_W    = 256,
  parameter int VIS_H    = 240,
  parameter int VBL_LINE = 241,
  parameter int ODD_SKIP = 1,
  parameter int FCNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              rendering_en,
  input  logic              nmi_en,
  input  logic              status_rd,
  output logic [8:0]        x_pos,
  output logic [8:0]        y_pos,
  output logic              visible,
  output logic              line_start,
  output logic              frame_start,
  output logic              vblank_flag,
  output logic              nmi_n,
  output logic              frame_odd,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam logic [8:0] Y_PRE  = 9'h1FF;
  localparam logic [8:0] X_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] X_SKIP = 9'(H_TOTAL - 2);
  localparam logic [8:0] Y_LAST = 9'(V_LINES - 2);
  localparam logic [8:0] Y_VBL  = 9'(VBL_LINE);
  localparam logic [8:0] X_VIS  = 9'(VIS_W);
  localparam logic [8:0] Y_VIS  = 9'(VIS_H);
  localparam logic       SKIP_ON = (ODD_SKIP != 32'sd0);
  localparam logic [FCNT_W-1:0] CNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

  logic [8:0]        x_r, y_r;
  logic [8:0]        x_nxt_s, y_nxt_s;
  logic              odd_r, odd_nxt_s;
  logic [FCNT_W-1:0] cnt_r, cnt_nxt_s;
  logic              flag_r, flag_nxt_s;
  logic              nmi_n_r;
  logic              vis_r, ls_r, fs_r;
  logic              skip_s, vbl_set_s, vbl_clr_s;

  assign skip_s    = en && SKIP_ON && odd_r && rendering_en && (y_r == Y_PRE) && (x_r == X_SKIP);
  assign vbl_set_s = en && (y_r == Y_VBL) && (x_r == 9'd1);
  assign vbl_clr_s = en && (y_r == Y_PRE) && (x_r == 9'd1);

  // Next dot/line position, frame parity and frame count.
  always_comb begin
    x_nxt_s   = x_r;
    y_nxt_s   = y_r;
    odd_nxt_s = odd_r;
    cnt_nxt_s = cnt_r;
    if (!en) begin
      x_nxt_s = x_r;
    end else if (skip_s) begin
      x_nxt_s = 9'd0;
      y_nxt_s = 9'd0;
    end else if (x_r == X_LAST) begin
      x_nxt_s = 9'd0;
      if (y_r == Y_PRE) begin
        y_nxt_s = 9'd0;
      end else if (y_r == Y_LAST) begin
        // The pre-render line already belongs to the next frame.
        y_nxt_s   = Y_PRE;
        odd_nxt_s = ~odd_r;
        cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
        y_nxt_s = y_r + 9'd1;
      end
    end else begin
      x_nxt_s = x_r + 9'd1;
    end
  end

  // Vblank flag; a CPU status read wins over a coincident set event.
  always_comb begin
    flag_nxt_s = flag_r;
    if (status_rd) begin
      flag_nxt_s = 1'b0;
    end else if (vbl_set_s) begin
      flag_nxt_s = 1'b1;
    end else if (vbl_clr_s) begin
      flag_nxt_s = 1'b0;
    end else begin
      flag_nxt_s = flag_r;
    end
  end

  // State registers; position decodes are registered from the next position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r     <= 9'd0;
      y_r     <= Y_PRE;
      odd_r   <= 1'b0;
      cnt_r   <= {FCNT_W{1'b0}};
      flag_r  <= 1'b0;
      nmi_n_r <= 1'b1;
      vis_r   <= 1'b0;
      ls_r    <= 1'b1;
      fs_r    <= 1'b0;
    end else begin
      x_r     <= x_nxt_s;
      y_r     <= y_nxt_s;
      odd_r   <= odd_nxt_s;
      cnt_r   <= cnt_nxt_s;
      flag_r  <= flag_nxt_s;
      nmi_n_r <= ~(flag_nxt_s & nmi_en);
      vis_r   <= (x_nxt_s < X_VIS) && (y_nxt_s < Y_VIS);
      ls_r    <= (x_nxt_s == 9'd0);
      fs_r    <= (x_nxt_s == 9'd0) && (y_nxt_s == 9'd0);
    end
  end

  assign x_pos       = x_r;
  assign y_pos       = y_r;
  assign visible     = vis_r;
  assign line_start  = ls_r;
  assign frame_start = fs_r;
  assign vblank_flag = flag_r;
  assign nmi_n       = nmi_n_r;
  assign frame_odd   = odd_r;
  assign frame_cnt   = cnt_r;

endmodule

// File: tb/tb_ppu_raster_timing.sv
// Scoreboard bench for ppu_raster_timing on a reduced raster (20 dots x 12 lines)
// so several whole frames fit in a short run.
module tb_ppu_raster_timing;

  localparam int K_LS = 0, K_FS = 1, K_VR = 2, K_VF = 3, K_NF = 4, K_NR = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, rendering_en = 1'b0, nmi_en = 1'b0, status_rd = 1'b0;
  logic [8:0]  x_pos, y_pos;
  logic        visible, line_start, frame_start, vblank_flag, nmi_n, frame_odd;
  logic [15:0] frame_cnt;

  typedef struct { int kind; int cyc; int val; } ev_t;
  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc;
  logic mon_ls = 1'b0;

  ppu_raster_timing #(
    .H_TOTAL(20), .V_LINES(12), .VIS_W(16), .VIS_H(8), .VBL_LINE(9), .ODD_SKIP(1), .FCNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rendering_en(rendering_en), .nmi_en(nmi_en),
    .status_rd(status_rd), .x_pos(x_pos), .y_pos(y_pos), .visible(visible),
    .line_start(line_start), .frame_start(frame_start), .vblank_flag(vblank_flag),
    .nmi_n(nmi_n), .frame_odd(frame_odd), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Cycle stamp: equals the dot index since reset release while en stays high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic push(input int k, input int c, input int v);
    ev_t e;
    e.kind = k; e.cyc = c; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic got(input int k, input int v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d val=%0h", k, cyc, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.val != v) begin
        errors++;
        $display("FAIL event got kind=%0d cyc=%0d val=%0h expected kind=%0d cyc=%0d val=%0h",
                 k, cyc, v, e.kind, e.cyc, e.val);
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic drain(input string nm);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_events got %0d pending expected 0 (next kind=%0d cyc=%0d)",
               nm, exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
    end
    exp_q.delete();
  endtask

  task automatic start(input logic r_en, input logic n_en, input logic ls_on);
    rst_n = 1'b0;
    en = 1'b1; rendering_en = r_en; nmi_en = n_en; status_rd = 1'b0; mon_ls = ls_on;
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: turns output edges into events and checks them against the queue.
  initial begin
    logic p_ls, p_fs, p_vb, p_nmi;
    p_ls = 1'b1; p_fs = 1'b0; p_vb = 1'b0; p_nmi = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_ls = 1'b1; p_fs = 1'b0; p_vb = 1'b0; p_nmi = 1'b1;
      end else begin
        if (mon_ls && line_start && !p_ls) got(K_LS, {23'd0, y_pos});
        if (frame_start && !p_fs)          got(K_FS, {15'd0, frame_odd, frame_cnt});
        if (vblank_flag && !p_vb)          got(K_VR, 0);
        if (!vblank_flag && p_vb)          got(K_VF, 0);
        if (!nmi_n && p_nmi)               got(K_NF, 0);
        if (nmi_n && !p_nmi)               got(K_NR, 0);
        p_ls = line_start; p_fs = frame_start; p_vb = vblank_flag; p_nmi = nmi_n;
      end
    end
  end

  initial begin
    // A: reset state, line sequence, vblank/NMI span, no skip with rendering off.
    start(1'b0, 1'b1, 1'b1);
    chk("rst_x", x_pos, 0);
    chk("rst_y", y_pos, 'h1FF);
    chk("rst_visible", visible, 0);
    chk("rst_line_start", line_start, 1);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_vblank", vblank_flag, 0);
    chk("rst_nmi_n", nmi_n, 1);
    chk("rst_odd", frame_odd, 0);
    chk("rst_cnt", frame_cnt, 0);
    push(K_LS, 20, 0);
    push(K_FS, 20, 0);
    for (int y = 1; y <= 9; y++) push(K_LS, 20 + 20 * y, y);
    push(K_VR, 202, 0);
    push(K_NF, 202, 0);
    push(K_LS, 220, 10);
    push(K_LS, 240, 'h1FF);
    push(K_VF, 242, 0);
    push(K_NR, 242, 0);
    push(K_LS, 260, 0);
    push(K_FS, 260, 'h10001);
    wait_cyc(35);  chk("vis_y0_x15", visible, 1);
    wait_cyc(36);  chk("vis_y0_x16", visible, 0);
    wait_cyc(175); chk("vis_y7_x15", visible, 1);
    wait_cyc(180); chk("vis_y8_x0", visible, 0);
    wait_cyc(265);
    drain("A");

    // B: rendering on, odd frames drop one pre-render dot.
    start(1'b1, 1'b0, 1'b0);
    push(K_FS, 20, 0);
    push(K_VR, 202, 0);
    push(K_VF, 242, 0);
    push(K_FS, 259, 'h10001);
    push(K_VR, 441, 0);
    push(K_VF, 481, 0);
    push(K_FS, 499, 'h00002);
    push(K_VR, 681, 0);
    push(K_VF, 721, 0);
    push(K_FS, 738, 'h10003);
    wait_cyc(745);
    drain("B");

    // C: status read racing the set event, then one cycle after it.
    start(1'b0, 1'b1, 1'b0);
    push(K_FS, 20, 0);
    push(K_FS, 260, 'h10001);
    push(K_VR, 442, 0);
    push(K_NF, 442, 0);
    push(K_VF, 443, 0);
    push(K_NR, 443, 0);
    wait_cyc(201); status_rd = 1'b1;
    @(negedge clk); status_rd = 1'b0;
    wait_cyc(442); status_rd = 1'b1;
    @(negedge clk); status_rd = 1'b0;
    wait_cyc(495);
    drain("C");

    // D: NMI enable toggled while the flag is set.
    start(1'b0, 1'b0, 1'b0);
    push(K_FS, 20, 0);
    push(K_VR, 202, 0);
    push(K_NF, 226, 0);
    push(K_NR, 231, 0);
    push(K_VF, 242, 0);
    push(K_FS, 260, 'h10001);
    wait_cyc(225); nmi_en = 1'b1;
    wait_cyc(230); nmi_en = 1'b0;
    wait_cyc(265);
    drain("D");

    // E: 100-cycle dot-enable hold, then asynchronous reset mid-line.
    start(1'b0, 1'b1, 1'b0);
    push(K_FS, 20, 0);
    push(K_VR, 302, 0);
    push(K_NF, 302, 0);
    push(K_VF, 342, 0);
    push(K_NR, 342, 0);
    push(K_FS, 360, 'h10001);
    wait_cyc(85);  en = 1'b0;
    wait_cyc(150);
    chk("freeze_x", x_pos, 5);
    chk("freeze_y", y_pos, 3);
    chk("freeze_cnt", frame_cnt, 0);
    wait_cyc(185); en = 1'b1;
    wait_cyc(365);
    chk("pre_rst_x", x_pos, 5);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_x", x_pos, 0);
    chk("async_rst_y", y_pos, 'h1FF);
    chk("async_rst_cnt", frame_cnt, 0);
    chk("async_rst_odd", frame_odd, 0);
    chk("async_rst_vblank", vblank_flag, 0);
    drain("E");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
